// File: rtl/mem_pkg.sv
// mem_pkg: arbiter state encoding and grant mode encodings shared by the refill path.
package mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DELIVER} arb_state_t;
  localparam logic [1:0] MODE_I    = 2'b10;
  localparam logic [1:0] MODE_D    = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b00;
endpackage

// File: rtl/refill_timeout_ctr.sv
// refill_timeout_ctr: counts WAIT cycles; load marks the first WAIT cycle as 1,
// expire is high during the TIMEOUT_CYCLES-th WAIT cycle.
module refill_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    expire = cnt_q == CW'(TIMEOUT_CYCLES);
    cnt_d  = load ? CW'(1) : (en && !expire) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/flash_refill_arbiter.sv
// flash_refill_arbiter: shares one SPI flash reader between L1I and L1D refills.
// Define ARB_STATS_EN to get saturating per-cache grant counters.
module flash_refill_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STAT_W         = 16
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              spi_ready,
  output logic              spi_start,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_data_valid,
  input  logic [DATA_W-1:0] spi_data,
  output logic [DATA_W-1:0] fill_data,
  output logic              icache_fill,
  output logic              dcache_fill,
  output logic [1:0]        mode,
  output logic              busy,
  output logic              timeout_err,
  output logic [STAT_W-1:0] icache_grants,
  output logic [STAT_W-1:0] dcache_grants
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic [1:0]        mode_q, mode_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant, i_win, issue, expire;

  refill_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .CLK    (CLK),
    .resetn (resetn),
    .load   (issue),
    .en     (state_q == ARB_WAIT),
    .expire (expire)
  );

  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      spi_addr_q  <= '0;
      fill_data_q <= '0;
      mode_q      <= MODE_NONE;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      spi_addr_q  <= spi_addr_d;
      fill_data_q <= fill_data_d;
      mode_q      <= mode_d;
      starve_q    <= starve_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  state_d = grant ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_d = spi_ready ? ARB_WAIT : ARB_ISSUE;
      ARB_WAIT:  state_d = spi_data_valid ? ARB_DELIVER : expire ? ARB_IDLE : ARB_WAIT;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // D normally wins; I is forced through once D has been granted STARVE_LIMIT times in a row
  always_comb begin
    grant       = state_q == ARB_IDLE && (icache_req || dcache_req);
    i_win       = icache_req && (!dcache_req || starve_q == SW'(STARVE_LIMIT));
    issue       = state_q == ARB_ISSUE && spi_ready;
    spi_addr_d  = grant ? (i_win ? icache_addr : dcache_addr) : spi_addr_q;
    fill_data_d = (state_q == ARB_WAIT && spi_data_valid) ? spi_data : fill_data_q;
    mode_d      = grant ? (i_win ? MODE_I : MODE_D) :
                  (state_q == ARB_DELIVER || timeout_err) ? MODE_NONE : mode_q;
    starve_d    = (!icache_req || (grant && i_win)) ? '0 :
                  (grant && starve_q < SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
  end

  always_comb begin
    spi_start   = issue;
    spi_addr    = spi_addr_q;
    fill_data   = fill_data_q;
    mode        = mode_q;
    busy        = state_q != ARB_IDLE;
    timeout_err = state_q == ARB_WAIT && !spi_data_valid && expire;
    icache_fill = state_q == ARB_DELIVER && mode_q == MODE_I && icache_req;
    dcache_fill = state_q == ARB_DELIVER && mode_q == MODE_D && dcache_req;
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] i_grants_q, i_grants_d, d_grants_q, d_grants_d;
  always_comb begin
    i_grants_d = (issue && mode_q == MODE_I && !(&i_grants_q)) ? i_grants_q + STAT_W'(1) : i_grants_q;
    d_grants_d = (issue && mode_q == MODE_D && !(&d_grants_q)) ? d_grants_q + STAT_W'(1) : d_grants_q;
  end
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      i_grants_q <= '0;
      d_grants_q <= '0;
    end else begin
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
    end
  assign icache_grants = i_grants_q;
  assign dcache_grants = d_grants_q;
`else
  assign icache_grants = '0;
  assign dcache_grants = '0;
`endif
endmodule

// File: tb/tb_flash_refill_arbiter.sv
// tb_flash_refill_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_flash_refill_arbiter;
  localparam int LIM = 4;
  localparam int TMO = 16;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 0, resetn = 0;
  logic        ir = 0, dr = 0, rdy = 0, v = 0;
  logic [19:0] ia = 0, da = 0;
  logic [31:0] sd = 0;
  logic        spi_start, fi, fd, busy, tmo;
  logic [19:0] spi_addr;
  logic [31:0] fill_data;
  logic [1:0]  mode;
  logic [15:0] ig, dg;

  flash_refill_arbiter #(.ADDR_W(20), .DATA_W(32), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO), .STAT_W(16)) dut (
    .CLK(CLK), .resetn(resetn), .icache_req(ir), .icache_addr(ia), .dcache_req(dr), .dcache_addr(da),
    .spi_ready(rdy), .spi_start(spi_start), .spi_addr(spi_addr), .spi_data_valid(v), .spi_data(sd),
    .fill_data(fill_data), .icache_fill(fi), .dcache_fill(fd), .mode(mode), .busy(busy),
    .timeout_err(tmo), .icache_grants(ig), .dcache_grants(dg)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  // reference model: the one transaction in flight, if any
  bit          m_act, m_who, m_iss, m_have;
  logic [19:0] m_addr;
  logic [31:0] m_data;
  int          m_wc, m_starve, m_ig, m_dg;
  // observations and stimulus knobs
  int          cyc = 0, n_start, n_fi, n_fd, n_tmo, start_cyc, tmo_cyc, rsp_cnt;
  logic [1:0]  start_mode[$];
  logic [19:0] start_addr[$];
  logic [31:0] last_fill, fix_data;
  bit          fi_seen, fd_seen, start_seen;
  bit          raise_en, drop_en, hold_d, spur_en, fix_en, rdy_rand;
  int          lat_mode;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] stat_exp(int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic model_reset();
    m_act = 0; m_who = 0; m_iss = 0; m_have = 0; m_addr = 0; m_data = 0;
    m_wc = 0; m_starve = 0; m_ig = 0; m_dg = 0;
    rsp_cnt = 0; fi_seen = 0; fd_seen = 0; start_seen = 0; v = 0;
  endtask

  task automatic clr();
    n_start = 0; n_fi = 0; n_fd = 0; n_tmo = 0;
    start_mode.delete(); start_addr.delete();
  endtask

  task automatic drive();
    rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    v = 0;
    if (start_seen)
      rsp_cnt = lat_mode < 0 ? 0 : lat_mode > 0 ? lat_mode :
                ($urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 3)));
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      v = rsp_cnt == 0;
    end else if (spur_en) v = $urandom_range(0, 15) == 0;
    sd = (v && fix_en) ? fix_data : $urandom;
    if (fi_seen) ir = 0;
    else if (ir) begin
      if (drop_en && $urandom_range(0, 63) == 0) ir = 0;
      else if (drop_en && $urandom_range(0, 15) == 0) ia = 20'($urandom);
    end else if (raise_en && $urandom_range(0, 2) == 0) begin
      ir = 1; ia = 20'($urandom);
    end
    if (fd_seen && !hold_d) dr = 0;
    else if (dr) begin
      if (drop_en && $urandom_range(0, 63) == 0) dr = 0;
      else if (drop_en && $urandom_range(0, 15) == 0) da = 20'($urandom);
    end else if (raise_en && $urandom_range(0, 1) == 0) begin
      dr = 1; da = 20'($urandom);
    end
  endtask

  task automatic cycle();
    bit grant, iw, e_start, e_tmo, e_fi, e_fd;
    logic [1:0] e_mode;
    @(negedge CLK);
    e_mode  = !m_act ? 2'b00 : m_who ? 2'b10 : 2'b01;
    e_start = m_act && !m_iss && rdy;
    e_tmo   = m_act && m_iss && !m_have && !v && m_wc == TMO;
    e_fi    = m_act && m_have && m_who && ir;
    e_fd    = m_act && m_have && !m_who && dr;
    check("busy", 64'(busy), 64'(m_act));
    check("mode", 64'(mode), 64'(e_mode));
    check("spi_start", 64'(spi_start), 64'(e_start));
    check("spi_addr", 64'(spi_addr), 64'(m_addr));
    check("timeout_err", 64'(tmo), 64'(e_tmo));
    check("icache_fill", 64'(fi), 64'(e_fi));
    check("dcache_fill", 64'(fd), 64'(e_fd));
    check("fill_data", 64'(fill_data), 64'(m_data));
    check("icache_grants", 64'(ig), stat_exp(m_ig));
    check("dcache_grants", 64'(dg), stat_exp(m_dg));
    start_seen = spi_start; fi_seen = fi; fd_seen = fd;
    if (spi_start) begin
      n_start++; start_cyc = cyc;
      start_mode.push_back(mode); start_addr.push_back(spi_addr);
    end
    if (fi || fd) last_fill = fill_data;
    if (fi) n_fi++;
    if (fd) n_fd++;
    if (tmo) begin n_tmo++; tmo_cyc = cyc; end
    grant = !m_act && (ir || dr);
    iw    = ir && (!dr || m_starve == LIM);
    if (!ir || (grant && iw)) m_starve = 0;
    else if (grant && m_starve < LIM) m_starve++;
    if (!m_act) begin
      if (grant) begin
        m_act = 1; m_who = iw; m_addr = iw ? ia : da; m_iss = 0; m_have = 0;
      end
    end else if (!m_iss) begin
      if (rdy) begin
        m_iss = 1; m_wc = 1;
        if (m_who) m_ig++; else m_dg++;
      end
    end else if (!m_have) begin
      if (v) begin m_have = 1; m_data = sd; end
      else if (m_wc == TMO) m_act = 0;
      else m_wc++;
    end else m_act = 0;
    cyc++;
    @(posedge CLK);
    #1;
    drive();
  endtask

  initial begin
    raise_en = 0; drop_en = 0; hold_d = 0; spur_en = 0; fix_en = 0; rdy_rand = 0;
    lat_mode = 1; fix_data = 0; last_fill = 0;
    model_reset(); clr();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_mode", 64'(mode), 0);
    check("rst_spi_start", 64'(spi_start), 0);
    check("rst_spi_addr", 64'(spi_addr), 0);
    check("rst_fill_data", 64'(fill_data), 0);
    check("rst_fills", 64'({fi, fd, tmo}), 0);
    check("rst_grants", 64'({ig, dg}), 0);
    resetn = 1;

    // single I refill, 3-cycle flash
    rdy = 1; lat_mode = 3; fix_en = 1; fix_data = 32'hDEADBEEF;
    ir = 1; ia = 20'h00100;
    for (int k = 0; k < 12; k++) cycle();
    check("t1_starts", 64'(n_start), 1);
    check("t1_addr", 64'(start_addr.size() > 0 ? start_addr[0] : 20'hFFFFF), 64'h00100);
    check("t1_mode", 64'(start_mode.size() > 0 ? start_mode[0] : 2'b11), 64'b10);
    check("t1_fills", 64'(n_fi), 1);
    check("t1_data", 64'(last_fill), 64'hDEADBEEF);

    // simultaneous requests: D first, then I
    clr(); fix_en = 0; lat_mode = 1;
    ir = 1; ia = 20'h00200; dr = 1; da = 20'hAF004;
    for (int k = 0; k < 20; k++) cycle();
    check("t2_starts", 64'(n_start), 2);
    check("t2_first_mode", 64'(start_mode.size() > 0 ? start_mode[0] : 2'b11), 64'b01);
    check("t2_first_addr", 64'(start_addr.size() > 0 ? start_addr[0] : 20'hFFFFF), 64'hAF004);
    check("t2_second_mode", 64'(start_mode.size() > 1 ? start_mode[1] : 2'b11), 64'b10);
    check("t2_second_addr", 64'(start_addr.size() > 1 ? start_addr[1] : 20'hFFFFF), 64'h00200);
    check("t2_fills", 64'(n_fi + n_fd), 2);

    // starvation: D held continuously, I pending
    clr(); hold_d = 1;
    ir = 1; ia = 20'h0ABCD; dr = 1; da = 20'h51234;
    for (int k = 0; k < 80 && n_start < 5; k++) cycle();
    for (int i = 0; i < 5; i++)
      check("t3_grant_order", 64'(start_mode.size() > i ? start_mode[i] : 2'b11), i == 4 ? 64'b10 : 64'b01);
    hold_d = 0;
    for (int k = 0; k < 20; k++) cycle();

    // timeout with no flash response, then re-arbitration
    clr(); lat_mode = -1;
    dr = 1; da = 20'h33333;
    for (int k = 0; k < 40 && n_tmo == 0; k++) cycle();
    check("t4_timeouts", 64'(n_tmo), 1);
    check("t4_tmo_wait_cycles", 64'(tmo_cyc - start_cyc), 16);
    lat_mode = 1;
    for (int k = 0; k < 10 && n_start < 2; k++) cycle();
    check("t4_restart", 64'(n_start), 2);
    check("t4_restart_gap", 64'(start_cyc - tmo_cyc), 2);
    for (int k = 0; k < 10 && n_fd == 0; k++) cycle();
    check("t4_fill", 64'(n_fd), 1);

    // D drops its request while the read is in flight
    clr(); lat_mode = 3; fix_en = 1; fix_data = 32'h12345678;
    dr = 1; da = 20'h44444;
    for (int k = 0; k < 10 && n_start == 0; k++) cycle();
    dr = 0;
    for (int k = 0; k < 8; k++) cycle();
    check("t5_no_fill", 64'(n_fd), 0);
    check("t5_busy", 64'(busy), 0);
    check("t5_data", 64'(fill_data), 64'h12345678);
    fix_en = 0;

    // reset while waiting on the flash
    clr(); lat_mode = -1;
    ir = 1; ia = 20'h55555;
    for (int k = 0; k < 10 && n_start == 0; k++) cycle();
    cycle(); cycle();
    resetn = 0; ir = 0;
    #1;
    check("t6_busy", 64'(busy), 0);
    check("t6_mode", 64'(mode), 0);
    check("t6_spi_addr", 64'(spi_addr), 0);
    check("t6_outs", 64'({spi_start, fi, fd, tmo}), 0);
    check("t6_grants", 64'({ig, dg}), 0);
    model_reset(); clr();
    @(posedge CLK);
    #1;
    resetn = 1;
    lat_mode = 1;
    for (int k = 0; k < 6; k++) cycle();
    check("t6_no_restart", 64'(n_start), 0);
    for (int g = 0; g < 3; g++) begin
      ir = 1; ia = 20'($urandom);
      for (int k = 0; k < 20 && n_fi <= g; k++) cycle();
    end
    cycle();
    check("t6_icache_grants", 64'(ig), stat_exp(3));

    // randomized traffic
    raise_en = 1; drop_en = 1; spur_en = 1; rdy_rand = 1; lat_mode = 0;
    for (int k = 0; k < 3000; k++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
